// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART receive path.
//   rxState_t      : receiver FSM states
//   PAR_*          : parity_mode encodings
//   DB_*           : data_bits encodings (word length 5..8)
//   lastBitIdx()   : index of the final data bit for a data_bits code
//   parityOn()     : true when a parity bit is present in the frame
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rxState_t;

    localparam logic [1:0] PAR_NONE     = 2'b00;
    localparam logic [1:0] PAR_EVEN     = 2'b01;
    localparam logic [1:0] PAR_ODD      = 2'b10;
    localparam logic [1:0] PAR_NONE_ALT = 2'b11;

    localparam logic [1:0] DB_5 = 2'b00;
    localparam logic [1:0] DB_6 = 2'b01;
    localparam logic [1:0] DB_7 = 2'b10;
    localparam logic [1:0] DB_8 = 2'b11;

    // Bit periods of quiet line before idle asserts.
    localparam logic [4:0] IDLE_BITS = 5'd16;

    // DB_5 -> 4 ... DB_8 -> 7
    function automatic logic [2:0] lastBitIdx(input logic [1:0] dataBits);
        return 3'(dataBits) + 3'd4;
    endfunction

    function automatic logic parityOn(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo -- first-word-fall-through synchronous FIFO.
//   clk, rst   : clock, synchronous active-high reset
//   wrEn       : push request; taken when not full, or when full with a pop
//   wrData     : word to push
//   rdEn       : pop request; ignored while empty
//   rdData     : head word (0 while empty)
//   valid      : head word present
//   full       : occupancy == DEPTH
//   count      : current occupancy
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wrEn,
    input  logic [WIDTH-1:0]         wrData,
    input  logic                     rdEn,
    output logic [WIDTH-1:0]         rdData,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;

    assign valid  = (count != '0);
    assign full   = (count == (AW+1)'(DEPTH));
    assign doPop  = rdEn && valid;
    // A full FIFO still accepts a push when the head leaves in the same clock;
    // the write slot is the one being vacated.
    assign doPush = wrEn && (!full || doPop);
    assign rdData = valid ? mem[rdPtr] : '0;

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= wrData;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (doPop)  rdPtr <= rdPtr + AW'(1);
            case ({doPush, doPop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param -- oversampling UART receiver with receive FIFO.
//   clk, rst      : clock, synchronous active-high reset
//   rxd           : asynchronous serial input, idle high
//   baud_div      : clocks per oversample tick minus 1
//   data_bits     : word length code (5..8 bits)
//   parity_mode   : none / even / odd / none
//   stop2         : expect two stop bits
//   m_valid/m_ready/m_data/m_perr/m_ferr : FWFT receive stream
//   overrun       : sticky, a word was dropped on a full FIFO; ovr_clr clears
//   break_det     : one-clock pulse on a break frame
//   idle          : no frame started for 16 bit periods
//   fifo_count    : FIFO occupancy
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int OVS        = 16,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rxd,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic [1:0]                    data_bits,
    input  logic [1:0]                    parity_mode,
    input  logic                          stop2,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [7:0]                    m_data,
    output logic                          m_perr,
    output logic                          m_ferr,
    output logic                          overrun,
    input  logic                          ovr_clr,
    output logic                          break_det,
    output logic                          idle,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int TW = $clog2(OVS);
    localparam logic [TW-1:0] T_LAST = TW'(OVS - 1);
    localparam logic [TW-1:0] T_S0   = TW'(OVS/2 - 1);
    localparam logic [TW-1:0] T_S1   = TW'(OVS/2);
    localparam logic [TW-1:0] T_S2   = TW'(OVS/2 + 1);

    logic [DIV_W-1:0] divCnt;
    logic             tick;
    logic             rxMeta;
    logic             rxSync;

    rxState_t         state;
    logic [TW-1:0]    tickCnt;
    logic [TW-1:0]    nextTick;
    logic             samp0;
    logic             samp1;
    logic             vote;
    logic [2:0]       bitIdx;
    logic [1:0]       cfgBits;
    logic [1:0]       cfgPar;
    logic             cfgStop2;
    logic             stopIdx;
    logic [7:0]       dataReg;
    logic             parBit;
    logic             ferrAcc;
    logic             breakCand;
    logic             breakHold;
    logic [4:0]       idleCnt;
    logic             perrCalc;

    logic             pushVld;
    logic [9:0]       pushWord;
    logic [9:0]       headWord;
    logic             fifoFull;
    logic             pop;

    // Oversample tick: fires when the divisor counter is at 0, then reloads.
    assign tick = (divCnt == '0);

    always_ff @(posedge clk) begin
        if (rst)       divCnt <= '0;
        else if (tick) divCnt <= baud_div;
        else           divCnt <= divCnt - DIV_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
        end else begin
            rxMeta <= rxd;
            rxSync <= rxMeta;
        end
    end

    // Third vote sample is the live synchronized line at tick OVS/2+1.
    assign vote     = (samp0 & samp1) | (samp0 & rxSync) | (samp1 & rxSync);
    assign nextTick = (tickCnt == T_LAST) ? '0 : tickCnt + TW'(1);
    // dataReg bits above the word length stay 0, so XOR over all 8 is safe.
    assign perrCalc = parityOn(cfgPar) ? (^dataReg ^ parBit ^ (cfgPar == PAR_ODD)) : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            tickCnt   <= '0;
            samp0     <= 1'b1;
            samp1     <= 1'b1;
            bitIdx    <= '0;
            cfgBits   <= DB_8;
            cfgPar    <= PAR_NONE;
            cfgStop2  <= 1'b0;
            stopIdx   <= 1'b0;
            dataReg   <= '0;
            parBit    <= 1'b0;
            ferrAcc   <= 1'b0;
            breakCand <= 1'b0;
            breakHold <= 1'b0;
            idleCnt   <= '0;
            pushVld   <= 1'b0;
            pushWord  <= '0;
            break_det <= 1'b0;
        end else begin
            pushVld   <= 1'b0;
            break_det <= 1'b0;
            if (tick) begin
                tickCnt <= nextTick;
                if (tickCnt == T_S0) samp0 <= rxSync;
                if (tickCnt == T_S1) samp1 <= rxSync;
                unique case (state)
                    ST_IDLE: begin
                        if (!rxSync) begin
                            // This tick is tick 0 of the start bit.
                            state     <= ST_START;
                            tickCnt   <= TW'(1);
                            cfgBits   <= data_bits;
                            cfgPar    <= parity_mode;
                            cfgStop2  <= stop2;
                            bitIdx    <= '0;
                            stopIdx   <= 1'b0;
                            dataReg   <= '0;
                            parBit    <= 1'b0;
                            ferrAcc   <= 1'b0;
                            breakCand <= 1'b1;
                            breakHold <= 1'b0;
                            idleCnt   <= '0;
                        end else if (tickCnt == T_LAST && idleCnt != IDLE_BITS) begin
                            idleCnt <= idleCnt + 5'd1;
                        end
                    end
                    ST_START: begin
                        if (tickCnt == T_S2 && vote) begin
                            state   <= ST_IDLE;   // false start
                            tickCnt <= '0;
                        end else if (tickCnt == T_LAST) begin
                            state <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (tickCnt == T_S2) begin
                            dataReg[bitIdx] <= vote;
                            if (vote) breakCand <= 1'b0;
                        end
                        if (tickCnt == T_LAST) begin
                            if (bitIdx == lastBitIdx(cfgBits))
                                state <= parityOn(cfgPar) ? ST_PARITY : ST_STOP;
                            else
                                bitIdx <= bitIdx + 3'd1;
                        end
                    end
                    ST_PARITY: begin
                        if (tickCnt == T_S2) begin
                            parBit <= vote;
                            if (vote) breakCand <= 1'b0;
                        end
                        if (tickCnt == T_LAST) state <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (breakHold) begin
                            // Break: wait for the line to recover before re-arming.
                            if (rxSync) begin
                                state     <= ST_IDLE;
                                tickCnt   <= '0;
                                breakHold <= 1'b0;
                            end
                        end else if (tickCnt == T_S2) begin
                            if (!stopIdx && breakCand && !vote) begin
                                break_det <= 1'b1;
                                breakHold <= 1'b1;
                            end else if (stopIdx || !cfgStop2) begin
                                // Last stop decided: leave mid-bit so the next
                                // start edge is caught promptly.
                                pushVld  <= 1'b1;
                                pushWord <= {perrCalc, ferrAcc | ~vote, dataReg};
                                state    <= ST_IDLE;
                                tickCnt  <= '0;
                            end else begin
                                ferrAcc <= ferrAcc | ~vote;
                            end
                        end else if (tickCnt == T_LAST) begin
                            stopIdx <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign idle = (idleCnt == IDLE_BITS);
    assign pop  = m_valid && m_ready;

    always_ff @(posedge clk) begin
        if (rst || ovr_clr)                 overrun <= 1'b0;
        else if (pushVld && fifoFull && !pop) overrun <= 1'b1;
    end

    sync_fifo #(
        .WIDTH (10),
        .DEPTH (FIFO_DEPTH)
    ) rxFifo (
        .clk    (clk),
        .rst    (rst),
        .wrEn   (pushVld),
        .wrData (pushWord),
        .rdEn   (m_ready),
        .rdData (headWord),
        .valid  (m_valid),
        .full   (fifoFull),
        .count  (fifo_count)
    );

    assign m_data = headWord[7:0];
    assign m_ferr = headWord[8];
    assign m_perr = headWord[9];

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter OVS, default 16, meaning oversample ticks per bit; legal values are even numbers 8..32.
REQ-002 SHALL have parameter DIV_W, default 16, meaning baud divisor width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, meaning receive FIFO entries; legal values are powers of two, 2..64.
REQ-004 SHALL have port clk, input, 1, system clock.
REQ-005 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-006 SHALL have port rxd, input, 1, asynchronous serial line; idle level is high.
REQ-007 SHALL have port baud_div, input, DIV_W, clocks per oversample tick minus 1.
REQ-008 SHALL have port data_bits, input, 2, word length: 00=5, 01=6, 10=7, 11=8.
REQ-009 SHALL have port parity_mode, input, 2, parity: 00=none, 01=even, 10=odd, 11=none.
REQ-010 SHALL have port stop2, input, 1, stop bits: 1 = two stop bits expected.
REQ-011 SHALL have port m_valid, output, 1, FIFO head valid.
REQ-012 SHALL have port m_ready, input, 1, consumer accept.
REQ-013 SHALL have port m_data, output, 8, received word; unused upper bits are 0.
REQ-014 SHALL have port m_perr, output, 1, parity error flag for the head word.
REQ-015 SHALL have port m_ferr, output, 1, framing error flag for the head word.
REQ-016 SHALL have port overrun, output, 1, sticky flag: a word was dropped because the FIFO was full.
REQ-017 SHALL have port ovr_clr, input, 1, clears overrun.
REQ-018 SHALL have port break_det, output, 1, one-clock pulse on break condition.
REQ-019 SHALL have port idle, output, 1, high when no frame has started for 16 bit periods.
REQ-020 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.

Function
REQ-021 SHALL generate one oversample tick when the divisor counter reaches 0, then reload it from baud_div; baud_div=0 SHALL produce a tick every clk.
REQ-022 SHALL pass rxd through a 2-flop synchronizer clocked every clk; the synchronizer's reset value is 1.
REQ-023 SHALL implement the FSM IDLE->START->DATA->PARITY->STOP->IDLE; PARITY is skipped when parity is none; STOP lasts 1 or 2 bits per stop2.
REQ-024 SHALL latch data_bits, parity_mode and stop2 on leaving IDLE; changes mid-frame SHALL take effect only at the next frame.
REQ-025 SHALL leave IDLE on the first tick where the synchronized rxd is 0.
REQ-026 SHALL decide every bit by a 2-of-3 majority vote of the samples at ticks OVS/2-1, OVS/2 and OVS/2+1 of that bit.
REQ-027 SHALL return to IDLE with no FIFO write, no flag and no pulse when the start-bit majority is 1 (false start).
REQ-028 SHALL shift data bits in LSB first.
REQ-029 SHALL set perr when the received parity mismatches the latched mode; perr SHALL be 0 when parity is none.
REQ-030 SHALL set ferr when any stop-bit majority is 0.
REQ-031 SHALL push {perr, ferr, data} into the FIFO on the clk after the last stop-bit decision; m_valid SHALL rise on the following clk if the FIFO was empty.
REQ-032 SHALL treat a frame as a break when all data bits, the parity bit (if enabled) and the first stop bit decide 0; on a break it SHALL pulse break_det, SHALL NOT push, and SHALL hold in STOP until 1 is sampled, then enter IDLE.
REQ-033 SHALL present a first-word-fall-through FIFO; a pop occurs iff m_valid && m_ready; m_data, m_perr and m_ferr SHALL be stable while m_valid && !m_ready.
REQ-034 SHALL, when a push meets a full FIFO with no pop in the same clk, drop the new word and set overrun; a push and pop in the same clk with the FIFO full SHALL both succeed, with no overrun.
REQ-035 SHALL give ovr_clr priority over a simultaneous overrun set, so overrun reads 0 afterwards.
REQ-036 SHALL hold m_valid at 0 when the FIFO is empty; a pop attempted on an empty FIFO SHALL be ignored.
REQ-037 SHALL count bit periods in IDLE, saturating at 16, with idle = count==16; leaving IDLE SHALL clear the count.

Reset
REQ-038 SHALL, on rst: set FSM=IDLE, FIFO empty, fifo_count=0, m_valid=0, m_data=0, m_perr=0, m_ferr=0, overrun=0, break_det=0, idle=0, idle count=0, divisor counter=0.
REQ-039 SHALL, on rst mid-frame, discard the partial word with no push and no flags.

Structure
REQ-040 SHALL place the FSM state enum, the parity-mode encodings and the data_bits decode constants in shared package uart_pkg.
REQ-041 SHALL implement the FIFO as sub-module sync_fifo, parametrised by width and depth, with FWFT behaviour and a count output.

Verification
REQ-042 SHALL verify: baud_div=12, OVS=16, 8N1, byte 0xA5 -> one push, m_data=0xA5, perr=0, ferr=0.
REQ-043 SHALL verify: 7E2 with 0x35 sent with wrong parity -> m_data=0x35, m_perr=1, m_ferr=0.
REQ-044 SHALL verify: a 3-tick low glitch on rxd -> no push, FSM returns to IDLE.
REQ-045 SHALL verify: 9 bytes sent with m_ready=0 and FIFO_DEPTH=8 -> fifo_count=8, overrun=1, head=byte 1; then ovr_clr -> overrun=0.
REQ-046 SHALL verify: rxd held low for 20 bit times -> exactly one break_det pulse, no push, and IDLE is re-entered after rxd returns high.
REQ-047 SHALL verify: rst asserted at data bit 4 -> all outputs at reset values; the next clean frame 0x3C is received correctly.
